// File: rtl/flash_ctrl_pkg.sv
// Shared types and helpers for the multi-channel LED flasher.
package flash_ctrl_pkg;

    typedef enum logic [1:0] {
        M_OFF    = 2'b00,
        M_STEADY = 2'b01,
        M_BLINK  = 2'b10,
        M_BURST  = 2'b11
    } flash_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } flash_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flash_ctrl_if.sv
// Control-side bundle of the flasher: enables, modes, config load and LED outputs.
interface flash_ctrl_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]   FLSH;
    logic [2*CHANNELS-1:0] MODE;
    logic                  LOAD;
    logic [CNT_W-1:0]      PERIOD_IN;
    logic [CNT_W-1:0]      ON_IN;
    logic [CHANNELS-1:0]   F;
    logic                  SYNC;

    modport master (output FLSH, MODE, LOAD, PERIOD_IN, ON_IN, input F, SYNC);
    modport slave  (input FLSH, MODE, LOAD, PERIOD_IN, ON_IN, output F, SYNC);
endinterface

// File: rtl/flash_ctrl_channel.sv
// One flasher channel: enable edge detect, run/pause FSM, phase and burst counters,
// per-channel copy of the blink config and the registered LED output.
//
// state   | meaning
// S_IDLE  | channel disabled, output low, waits for an enable rising edge
// S_RUN   | phase counting, output follows mode (steady or phase < on-time)
// S_PAUSE | burst dark half: phase counting, output low
module flash_channel
    import flash_ctrl_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int BURST_N    = 3,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_ON     = 100,
    parameter bit SYNC_EN    = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             tick_i,
    input  logic             flsh_i,
    input  flash_mode_e      mode_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] shadow_per_i,
    input  logic [CNT_W-1:0] shadow_on_i,
    output logic             f_o,
    output logic             sync_o
);

    localparam int BW = cnt_width(BURST_N + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_N - 1);

    flash_state_e     state_q, state_d;
    flash_mode_e      mode_q, mode_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             flsh_prev_q;
    logic             need_q, need_d;
    logic             f_q, f_d;
    logic             sync_q;

    logic             rise, stop, at_end, wrap, adopt;
    logic [CNT_W-1:0] eff_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            mode_q      <= M_OFF;
            phase_q     <= '0;
            per_q       <= CNT_W'(DEF_PERIOD);
            on_q        <= CNT_W'(DEF_ON);
            bcnt_q      <= '0;
            flsh_prev_q <= 1'b0;
            need_q      <= 1'b0;
            f_q         <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            per_q       <= per_d;
            on_q        <= on_d;
            bcnt_q      <= bcnt_d;
            flsh_prev_q <= flsh_i;
            need_q      <= need_d;
            f_q         <= f_d;
            sync_q      <= SYNC_EN & wrap;
        end
    end

    always_comb begin
        rise    = flsh_i & ~flsh_prev_q;
        stop    = ~flsh_i | (mode_i == M_OFF);
        // A zero period behaves as a one-tick period.
        eff_end = (per_q == '0) ? '0 : per_q - 1'b1;
        at_end  = (phase_q == eff_end);
        wrap    = tick_i & at_end & (state_q != S_IDLE) & ~stop;
        adopt   = need_q & ((state_q == S_IDLE) | wrap);

        state_d = state_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        per_d   = adopt ? shadow_per_i : per_q;
        on_d    = adopt ? shadow_on_i  : on_q;
        need_d  = load_i | (need_q & ~adopt);

        if (stop) begin
            state_d = S_IDLE;
            phase_d = '0;
            bcnt_d  = '0;
        end else if (state_q == S_IDLE) begin
            if (rise) begin
                state_d = S_RUN;
                mode_d  = mode_i;
                phase_d = '0;
                bcnt_d  = '0;
            end
        end else begin
            if (mode_i == M_STEADY) begin
                mode_d  = M_STEADY;
                state_d = S_RUN;
            end
            if (wrap) begin
                phase_d = '0;
                mode_d  = mode_i;
                // Burst alternates RUN/PAUSE every BURST_N completed periods.
                if (mode_q == M_BURST) begin
                    if (bcnt_q == BURST_LAST) begin
                        bcnt_d  = '0;
                        state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                if (mode_i != M_BURST) begin
                    state_d = S_RUN;
                    bcnt_d  = '0;
                end
            end else if (tick_i) begin
                phase_d = phase_q + 1'b1;
            end
        end

        f_d = (state_d == S_RUN) & ((mode_d == M_STEADY) | (phase_d < on_d));
    end

    assign f_o    = f_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/flash_ctrl.sv
// Multi-channel LED flasher top: shared tick prescaler, shadow blink config and
// one flash_channel per output.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DIV        = 50000,
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_ON     = 100,
    parameter int BURST_N    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    flash_ctrl_if.slave bus
);

    localparam int PW = cnt_width(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [CNT_W-1:0]    shadow_per_q, shadow_per_d;
    logic [CNT_W-1:0]    shadow_on_q, shadow_on_d;
    logic [CHANNELS-1:0] f_v;
    logic [CHANNELS-1:0] sync_v;

    always_comb begin
        tick         = (presc_q == PRE_MAX);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        shadow_per_d = bus.LOAD ? bus.PERIOD_IN : shadow_per_q;
        shadow_on_d  = bus.LOAD ? bus.ON_IN     : shadow_on_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q      <= '0;
            shadow_per_q <= CNT_W'(DEF_PERIOD);
            shadow_on_q  <= CNT_W'(DEF_ON);
        end else begin
            presc_q      <= presc_d;
            shadow_per_q <= shadow_per_d;
            shadow_on_q  <= shadow_on_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Only channel 0 produces the SYNC pulse; the others tie it low.
        flash_channel #(
            .CNT_W     (CNT_W),
            .BURST_N   (BURST_N),
            .DEF_PERIOD(DEF_PERIOD),
            .DEF_ON    (DEF_ON),
            .SYNC_EN   (i == 0)
        ) u_ch (
            .CLK         (CLK),
            .RST         (RST),
            .tick_i      (tick),
            .flsh_i      (bus.FLSH[i]),
            .mode_i      (flash_mode_e'(bus.MODE[2*i +: 2])),
            .load_i      (bus.LOAD),
            .shadow_per_i(shadow_per_q),
            .shadow_on_i (shadow_on_q),
            .f_o         (f_v[i]),
            .sync_o      (sync_v[i])
        );
    end

    assign bus.F    = f_v;
    assign bus.SYNC = |sync_v;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: directed scenarios then random traffic, every
// cycle compared against a period/tick-level behavioural model.
module tb_flash_ctrl;

    localparam int CH  = 2;
    localparam int DIV = 2;
    localparam int CW  = 4;
    localparam int DP  = 4;
    localparam int DON = 2;
    localparam int BN  = 2;

    logic CLK = 1'b0;
    logic RST;

    flash_ctrl_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    flash_ctrl #(
        .CHANNELS(CH), .DIV(DIV), .CNT_W(CW),
        .DEF_PERIOD(DP), .DEF_ON(DON), .BURST_N(BN)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // stimulus copies
    logic [CH-1:0] flsh_v;
    logic [1:0]    mode_v [CH];
    logic          load_v;
    logic [CW-1:0] per_in, on_in;

    // reference model: channel running flag, tick count within period, completed periods
    int   cyc;
    bit   m_run [CH];
    bit   m_prev [CH];
    int   m_ph [CH];
    int   m_periods [CH];
    int   m_mode [CH];
    int   m_per [CH];
    int   m_on [CH];
    bit   m_need [CH];
    int   sh_per, sh_on;
    logic exp_f [CH];
    logic exp_sync;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        bus.FLSH = flsh_v;
        for (int i = 0; i < CH; i++) bus.MODE[2*i +: 2] = mode_v[i];
        bus.LOAD      = load_v;
        bus.PERIOD_IN = per_in;
        bus.ON_IN     = on_in;
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_prev[i] = 0; m_ph[i] = 0; m_periods[i] = 0;
            m_mode[i] = 0; m_per[i] = DP; m_on[i] = DON; m_need[i] = 0;
        end
        sh_per = DP;
        sh_on  = DON;
    endtask

    task automatic model_cycle();
        bit tick;
        tick = (cyc % DIV) == DIV - 1;
        cyc++;
        exp_sync = 1'b0;
        for (int i = 0; i < CH; i++) begin
            bit rise, was_run, wrapped, dark;
            int eff;
            rise    = flsh_v[i] && !m_prev[i];
            m_prev[i] = flsh_v[i];
            was_run = m_run[i];
            wrapped = 0;
            eff     = (m_per[i] == 0) ? 1 : m_per[i];
            if (!flsh_v[i] || mode_v[i] == 2'b00) begin
                m_run[i] = 0;
            end else if (!m_run[i]) begin
                if (rise) begin
                    m_run[i] = 1; m_ph[i] = 0; m_periods[i] = 0; m_mode[i] = int'(mode_v[i]);
                end
            end else if (tick) begin
                m_ph[i]++;
                if (m_ph[i] >= eff) begin
                    m_ph[i] = 0; m_periods[i]++; wrapped = 1;
                end
            end
            if (m_need[i] && (!was_run || wrapped)) begin
                m_per[i] = sh_per; m_on[i] = sh_on; m_need[i] = 0;
            end
            if (load_v) m_need[i] = 1;
            if (i == 0) exp_sync = wrapped;
            dark     = (m_mode[i] == 3) && ((m_periods[i] / BN) % 2 == 1);
            exp_f[i] = m_run[i] && (m_mode[i] == 1 || (!dark && m_ph[i] < m_on[i]));
        end
        if (load_v) begin
            sh_per = int'(per_in);
            sh_on  = int'(on_in);
        end
    endtask

    task automatic step();
        drive();
        model_cycle();
        @(posedge CLK);
        #1;
        for (int i = 0; i < CH; i++) check($sformatf("F%0d", i), bus.F[i], exp_f[i]);
        check("SYNC", bus.SYNC, exp_sync);
        load_v = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset asserted between edges; outputs must drop immediately.
    task automatic mid_reset();
        #2 RST = 1'b1;
        #1;
        check("rst_F0", bus.F[0], 1'b0);
        check("rst_F1", bus.F[1], 1'b0);
        check("rst_SYNC", bus.SYNC, 1'b0);
        flsh_v = '0;
        load_v = 1'b0;
        drive();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_hold_F0", bus.F[0], 1'b0);
        #2 RST = 1'b0;
        model_reset();
    endtask

    initial begin
        RST    = 1'b1;
        flsh_v = '0;
        for (int i = 0; i < CH; i++) mode_v[i] = 2'b00;
        load_v = 1'b0;
        per_in = '0;
        on_in  = '0;
        drive();
        #12;
        model_reset();
        RST = 1'b0;

        // reset in the middle of blinking
        mode_v[0] = 2'b10; mode_v[1] = 2'b10; flsh_v = 2'b01;
        run(14);
        mid_reset();
        run(10);

        // blink 4/4
        flsh_v[0] = 1'b1;
        run(40);

        // burst: two periods blinking, two dark
        flsh_v[0] = 1'b0; run(1);
        mode_v[0] = 2'b11; flsh_v[0] = 1'b1;
        run(80);

        // config load mid-period, then idle channel 1 enabled
        flsh_v[0] = 1'b0; run(1);
        mode_v[0] = 2'b10; flsh_v[0] = 1'b1;
        run(5);
        load_v = 1'b1; per_in = 4'd6; on_in = 4'd1;
        run(40);
        flsh_v[1] = 1'b1;
        run(30);

        // degenerate values
        load_v = 1'b1; per_in = 4'd6; on_in = 4'd0; run(40);
        load_v = 1'b1; per_in = 4'd4; on_in = 4'd9; run(30);
        load_v = 1'b1; per_in = 4'd0; on_in = 4'd1; run(20);
        load_v = 1'b1; per_in = CW'(DP); on_in = CW'(DON); run(20);

        // steady, enable fall, restart in blink
        flsh_v = '0; run(1);
        mode_v[0] = 2'b01; flsh_v[0] = 1'b1; run(10);
        flsh_v[0] = 1'b0; run(3);
        mode_v[0] = 2'b10; flsh_v[0] = 1'b1; run(20);

        // random traffic; modes only change while a channel is disabled
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(15) == 0) flsh_v[i] = ~flsh_v[i];
                if (!flsh_v[i] && $urandom_range(3) == 0) mode_v[i] = 2'($urandom_range(3));
            end
            if ($urandom_range(31) == 0) begin
                load_v = 1'b1;
                per_in = CW'($urandom_range(15));
                on_in  = CW'($urandom_range(15));
            end
            if (n == 700) mid_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
